// File: rtl/mux10_scan_ctrl_if.sv
// Bundle between the scan controller and its environment: frame control,
// the 10:1 mux data/select bus, and the serial valid/ready output.
interface mux10_scan_ctrl_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               abort;
  logic [DWELL_W-1:0] dwell;
  logic [9:0]         data_in;
  logic               mux_out;
  logic [9:0]         i_out;
  logic [3:0]         s_out;
  logic               ser_valid;
  logic               ser_ready;
  logic               ser_bit;
  logic [3:0]         ser_idx;
  logic               busy;
  logic               done;

  modport slave (
    input  start, abort, dwell, data_in, mux_out, ser_ready,
    output i_out, s_out, ser_valid, ser_bit, ser_idx, busy, done
  );

  modport master (
    output start, abort, dwell, data_in, mux_out, ser_ready,
    input  i_out, s_out, ser_valid, ser_bit, ser_idx, busy, done
  );
endinterface

// File: rtl/mux10_scan_ctrl.sv
// Paced 10-bit parallel-to-serial scanner driving an external 10:1 mux,
// LSB first, with a programmable settle time per channel.
module mux10_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux10_scan_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, DWELL, SAMPLE, FIN} state_t;

  state_t             state_q;
  logic [9:0]         i_q;
  logic [3:0]         s_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            i_q     <= bus.data_in;
            dwell_q <= bus.dwell;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DWELL;
          end
        end
        DWELL: begin
          if (bus.abort) begin
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == dwell_q) begin
              valid_q <= 1'b1;
              state_q <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          // Abort wins over a coincident handshake: that bit is dropped.
          if (bus.abort) begin
            s_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.ser_ready) begin
            valid_q <= 1'b0;
            if (s_q == 4'd9) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              s_q     <= s_q + 4'd1;
              cnt_q   <= '0;
              state_q <= DWELL;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          s_q     <= '0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          s_q     <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_out     = i_q;
  assign bus.s_out     = s_q;
  assign bus.ser_valid = valid_q;
  assign bus.ser_bit   = valid_q & bus.mux_out;
  assign bus.ser_idx   = s_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mux10_scan_ctrl.sv
// Bench for mux10_scan_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed bit streams and DONE latencies.
module tb_mux10_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux10_scan_ctrl_if #(.DWELL_W(8)) bus ();
  mux10_scan_ctrl #(.DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // Downstream 10:1 mux
  logic [15:0] iw;
  assign iw          = {6'b0, bus.i_out};
  assign bus.mux_out = iw[bus.s_out];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: channel index, cycles spent in the channel so far
  int         m_active, m_fin, m_ch, m_el, m_dw;
  logic [9:0] m_word;
  bit         rx[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_fin = 0; m_ch = 0; m_el = 0; m_dw = 0; m_word = '0;
    end else begin
      if (bus.ser_valid && bus.ser_ready && !bus.abort) rx.push_back(bus.ser_bit);
      if (m_fin != 0) m_fin = 0;
      else if (m_active == 0) begin
        if (bus.start) begin
          m_active = 1; m_ch = 0; m_el = 0;
          m_dw = int'(bus.dwell); m_word = bus.data_in;
        end
      end else if (bus.abort) m_active = 0;
      else if (m_el > m_dw) begin
        if (bus.ser_ready) begin
          if (m_ch == 9) begin m_active = 0; m_fin = 1; end
          else begin m_ch++; m_el = 0; end
        end
      end else m_el++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int ev, es;
      ev = (m_active != 0 && m_el > m_dw) ? 1 : 0;
      es = (m_active != 0) ? m_ch : ((m_fin != 0) ? 9 : 0);
      chk("busy",    int'(bus.busy),      m_active);
      chk("done",    int'(bus.done),      m_fin);
      chk("valid",   int'(bus.ser_valid), ev);
      chk("s_out",   int'(bus.s_out),     es);
      chk("ser_idx", int'(bus.ser_idx),   es);
      chk("i_out",   int'(bus.i_out),     int'(m_word));
      chk("ser_bit", int'(bus.ser_bit),   (ev != 0) ? int'(m_word[m_ch]) : 0);
    end
  end

  task automatic start_frame(input logic [9:0] d, input int dw);
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = d; bus.dwell = 8'(dw);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns edges from the START edge to the edge that raises DONE
  task automatic run_frame(input logic [9:0] d, input int dw, output int cyc);
    int n;
    n = 0; cyc = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = d; bus.dwell = 8'(dw);
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.done) begin cyc = n - 1; break; end
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_ch(input int idx);
    int n;
    n = 0;
    while (!(bus.ser_valid && int'(bus.ser_idx) == idx) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_ch_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic chk_rx(input string nm, input logic [9:0] w, input int cnt);
    chk({nm, "_count"}, rx.size(), cnt);
    for (int i = 0; i < cnt && i < rx.size(); i++) chk(nm, int'(rx[i]), int'(w[i]));
  endtask

  initial begin
    int cyc, dcount;
    bit exp2[10] = '{0, 1, 0, 1, 0, 0, 1, 1, 0, 1};
    bus.start = 1'b0; bus.abort = 1'b0; bus.dwell = '0; bus.data_in = '0; bus.ser_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sout", int'(bus.s_out), 0);
    chk("rst_iout", int'(bus.i_out), 0);
    chk("rst_valid", int'(bus.ser_valid), 0);

    // Async reset in the middle of a dwell
    start_frame(10'h3FF, 5);
    @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_iout", int'(bus.i_out), 0);
    chk("arst_sout", int'(bus.s_out), 0);
    chk("arst_valid", int'(bus.ser_valid), 0);
    chk("arst_done", int'(bus.done), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);

    // DWELL=0 frame
    rx.delete();
    run_frame(10'b10_1100_1010, 0, cyc);
    chk("t2_done_cycle", cyc, 20);
    chk("t2_count", rx.size(), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++) chk("t2_bit", int'(rx[i]), int'(exp2[i]));
    @(negedge clk);
    chk("t2_busy_after", int'(bus.busy), 0);

    // DWELL=3 frame
    rx.delete();
    run_frame(10'h3FF, 3, cyc);
    chk("t3_done_cycle", cyc, 50);
    chk_rx("t3_bit", 10'h3FF, 10);

    // Backpressure on channel 5
    rx.delete();
    start_frame(10'h2A5, 1);
    wait_ch(5);
    bus.ser_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(bus.ser_valid), 1);
      chk("t4_hold_idx", int'(bus.s_out), 5);
      chk("t4_hold_bit", int'(bus.ser_bit), 1);
    end
    chk("t4_rx_during_hold", rx.size(), 5);
    bus.ser_ready = 1'b1;
    wait_done();
    chk_rx("t4_bit", 10'h2A5, 10);

    // Abort coincident with a handshake on channel 3
    repeat (2) @(negedge clk);
    rx.delete();
    start_frame(10'h155, 1);
    wait_ch(3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_sout", int'(bus.s_out), 0);
    chk("t5_valid", int'(bus.ser_valid), 0);
    chk("t5_rx_count", rx.size(), 3);
    dcount = 0;
    repeat (8) begin @(negedge clk); if (bus.done) dcount++; end
    chk("t5_no_done", dcount, 0);
    rx.delete();
    run_frame(10'h0F0, 0, cyc);
    chk("t5_restart_cycle", cyc, 20);
    chk_rx("t5_bit", 10'h0F0, 10);

    // START during a frame and during FIN is ignored
    repeat (2) @(negedge clk);
    rx.delete();
    dcount = 0;
    start_frame(10'h0C3, 2);
    wait_ch(4);
    bus.start = 1'b1; bus.data_in = 10'h3FF; bus.dwell = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    if (bus.done) dcount++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.done) dcount++; end
    chk("t6_one_done", dcount, 1);
    chk("t6_iout", int'(bus.i_out), 10'h0C3);
    chk("t6_busy", int'(bus.busy), 0);
    chk_rx("t6_bit", 10'h0C3, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
